// File: rtl/rv_enc_pkg.sv
// Shared encodings for the RV32I instruction encoder/loader: class codes,
// opcodes, immediate range limits and the loader FSM state type.
package rv_enc_pkg;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_AUIPC  = 4'd7,
        CLS_LUI    = 4'd8
    } insn_class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    // Signed ranges of the 12-bit (I/S), 13-bit (B) and 21-bit (J) immediates.
    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4095;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048575;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic imm_fits(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/rv_inst_encoder.sv
// Combinational RV32I encoder: assembles a 32-bit word from decoded fields
// and flags illegal classes, misaligned control-flow offsets and range overflow.
module rv_inst_encoder
    import rv_enc_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        misaligned,
    output logic        range_err
);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        word       = NOP_INSN;
        illegal    = 1'b0;
        misaligned = 1'b0;
        range_err  = 1'b0;
        case (cls)
            CLS_R: word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
            CLS_I: begin
                range_err = !imm_fits(imm, IMM_I_MIN, IMM_I_MAX);
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_I};
                else
                    word = {imm[11:0], rs1, funct3, rd, OP_I};
            end
            CLS_LOAD: begin
                range_err = !imm_fits(imm, IMM_I_MIN, IMM_I_MAX);
                word      = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            end
            CLS_STORE: begin
                range_err = !imm_fits(imm, IMM_I_MIN, IMM_I_MAX);
                word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            end
            CLS_BRANCH: begin
                misaligned = imm[0];
                range_err  = !imm_fits(imm, IMM_B_MIN, IMM_B_MAX);
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            end
            CLS_JAL: begin
                misaligned = imm[0];
                range_err  = !imm_fits(imm, IMM_J_MIN, IMM_J_MAX);
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            CLS_JALR: begin
                range_err = !imm_fits(imm, IMM_I_MIN, IMM_I_MAX);
                word      = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            end
            CLS_AUIPC: word = {imm[31:12], rd, OP_AUIPC};
            CLS_LUI:   word = {imm[31:12], rd, OP_LUI};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: accepts field bundles, encodes them and writes the words to
// consecutive instruction-memory addresses starting at BASE_ADDR.
module inst_encoder_loader
    import rv_enc_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_class,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7b5,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_e                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [31:0]           word;
    logic                  illegal;
    logic                  misaligned;
    logic                  range_err;
    logic                  at_end;

    rv_inst_encoder u_enc (
        .cls        (in_class),
        .funct3     (in_funct3),
        .funct7b5   (in_funct7b5),
        .rd         (in_rd),
        .rs1        (in_rs1),
        .rs2        (in_rs2),
        .imm        (in_imm),
        .word       (word),
        .illegal    (illegal),
        .misaligned (misaligned),
        .range_err  (range_err)
    );

    assign at_end = (ptr == ADDR_LAST);
    assign busy   = (state != ST_IDLE);

    // in_ready drops the cycle after the final accept, so a bundle presented
    // during that write cycle is refused; RUN with in_ready low means "drain".
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
            ptr       <= BASE;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b1;
                        ptr      <= BASE;
                        count    <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!in_ready) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (in_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= word;
                        count     <= count + (ADDR_WIDTH+1)'(1);
                        if (!at_end)
                            ptr <= ptr + ADDR_WIDTH'(1);
                        if (illegal || misaligned || range_err || (at_end && !in_last))
                            err <= 1'b1;
                        if (in_last || at_end)
                            in_ready <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Sequential RV32I instruction encoder and program loader. It is the encode-side counterpart of the main control decoder: it accepts decoded instruction fields over a valid/ready stream, assembles the 32-bit instruction word, and writes the words into consecutive instruction-memory locations. It sits between the test/boot host interface and the single-cycle core's instruction memory write port.

Parameters:
ADDR_WIDTH, 10, word-address width of the instruction-memory write port
BASE_ADDR, 0, word address of the first instruction written after start

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a load session at BASE_ADDR (sampled in IDLE only)
in_valid  input  1  field bundle valid
in_ready  output  1  block accepts bundle this cycle
in_class  input  4  0 R, 1 I-arith, 2 load, 3 store, 4 branch, 5 jal, 6 jalr, 7 auipc, 8 lui; 9-15 illegal
in_funct3  input  3  funct3 field
in_funct7b5  input  1  instruction bit 30 for R-type and I-type shifts
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  immediate, byte offset, sign-extended; U-type supplies the full value with [11:0] ignored
in_last  input  1  final instruction of the session
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_WIDTH  word address of the write
mem_wdata  output  32  encoded instruction
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at session end
err  output  1  sticky error; cleared by start
count  output  ADDR_WIDTH+1  words written this session

Behaviour:
- Reset: state IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0, count=0. Reset mid-session aborts the session immediately; no partial write completes.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Entering RUN reloads the address pointer to BASE_ADDR and clears count and err.
  - In RUN, in_ready=1 every cycle (memory never stalls). accept = in_valid & in_ready.
  - RUN -> DONE on the cycle after the write for an accepted in_last, or on address overflow.
  - DONE lasts one cycle with done=1, then returns to IDLE.
  - start is ignored outside IDLE.
- Latency: a bundle accepted at cycle N produces mem_we=1, mem_addr=pointer and mem_wdata=encoding at cycle N+1.
  - After each write, the pointer increments by 1 and count increments by 1.
  - mem_we is low in every cycle without a preceding accept.
  - Back-to-back accepts give one write per cycle.
- Opcodes are full 7-bit with [1:0]=11: R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, auipc 0010111, lui 0110111.
- Encodings:
  - R: {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, op}.
  - I, load, jalr: {imm[11:0], rs1, f3, rd, op}. I-arith with f3=001 or 101 instead uses {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - jal and jalr force f3 as required (jalr f3=000). lui and auipc ignore f3.
- Errors (err set on the write cycle; the write still occurs):
  - Illegal class: word written is NOP 0x00000013.
  - Branch or jal with imm[0]=1: imm[0] is dropped and the word is encoded normally.
  - Immediate out of signed range for its format (12, 13 or 21 bits): field is truncated as above.
- Overflow: write at address 2^ADDR_WIDTH-1 without in_last sets err and goes to DONE. No wrap to 0.
- Simultaneous events: accept of in_last plus in_valid on the next cycle. Since in_ready is 0 in DONE, the following bundle is not accepted.

Decomposition:
- Package rv_enc_pkg holds:
  - class codes
  - 7-bit opcode constants
  - NOP_INSN = 32'h00000013
  - imm-range limits per format
- One combinational sub-module, rv_inst_encoder: fields in, {word, illegal, misaligned, range_err} out.
- The FSM, address pointer, count and output register stay in the top.

Test Plan:
- Reset release, start, then accept addi x1,x0,5 (class 1, f3 0, imm 5) -> next cycle mem_we=1, addr 0, wdata 0x00500093.
- Back-to-back: add x3,x1,x2 then sub x3,x1,x2 (f7b5=1) -> wdata 0x002081B3 at addr 0, then 0x402081B3 at addr 1 on consecutive cycles; count=2.
- Format coverage:
  - sw x2,8(x1) -> 0x0020A423
  - beq x0,x0,8 -> 0x00000463
  - jal x1,16 -> 0x010000EF
  - lui x5 with imm 0x12345000 -> 0x123452B7
- Errors:
  - class 12 -> wdata 0x00000013 and err=1.
  - Branch with imm=5 -> err=1, word encoded with imm 4.
  - err is cleared by the next start.
- Last bundle -> done pulses exactly one cycle after its write, then busy=0. in_valid held high afterwards -> no further mem_we.
- Overflow with ADDR_WIDTH=2: 5 non-last bundles -> 4 writes to addresses 0..3, err=1, done pulse, 5th bundle not accepted.
- Reset asserted mid-stream -> mem_we=0 immediately; all outputs return to their reset values.
